// File: rtl/multi_port_queue.sv
// multi_port_queue: in-order circular FIFO with NENQ enqueue lanes and NDEQ
// dequeue lanes per cycle. Requests are accepted or rejected as a whole;
// a rejection raises a sticky err flag. A synchronous flush empties the
// queue for mispredict recovery. Pointers carry a wrap bit so that a full
// queue and an empty queue can be told apart.
module multi_port_queue #(
  parameter int WIDTH     = 32,
  parameter int DEPTHEXP  = 3,
  parameter int NENQ      = 2,
  parameter int NDEQ      = 2,
  parameter int AF_MARGIN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [$clog2(NENQ+1)-1:0]  enq_num,
  input  logic [NENQ*WIDTH-1:0]      enq_data,
  output logic                       enq_ack,
  input  logic [$clog2(NDEQ+1)-1:0]  deq_num,
  output logic                       deq_ack,
  output logic [NDEQ*WIDTH-1:0]      deq_data,
  output logic [$clog2(NDEQ+1)-1:0]  deq_avail,
  output logic [DEPTHEXP:0]          count,
  output logic [DEPTHEXP:0]          free_slots,
  output logic                       almost_full,
  output logic                       err
);

  localparam int DEPTH = 1 << DEPTHEXP;
  localparam int PW    = DEPTHEXP + 1;
  localparam int DW    = $clog2(NDEQ + 1);

  // Architectural state
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [PW-1:0]    count_r;
  logic             err_r;
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Decoded request information
  logic [PW-1:0]    enq_num_w_s;
  logic [PW-1:0]    deq_num_w_s;
  logic [PW-1:0]    free_s;
  logic             enq_ack_s;
  logic             deq_ack_s;
  logic             enq_rej_s;
  logic             deq_rej_s;
  logic [PW-1:0]    enq_add_s;
  logic [PW-1:0]    deq_sub_s;
  logic [DW-1:0]    deq_avail_s;
  logic [NDEQ*WIDTH-1:0] deq_data_s;

  // Request widths and free space, all from start-of-cycle state
  always_comb begin
    enq_num_w_s = PW'(enq_num);
    deq_num_w_s = PW'(deq_num);
    free_s      = PW'(DEPTH) - count_r;
  end

  // Accept/reject decisions; free space for enqueue ignores same-cycle
  // dequeue so there is no combinational path from deq_num to enq_ack
  always_comb begin
    enq_ack_s = 1'b0;
    deq_ack_s = 1'b0;
    enq_rej_s = 1'b0;
    deq_rej_s = 1'b0;
    if (!rst && !flush) begin
      enq_ack_s = (enq_num_w_s != {PW{1'b0}}) && (enq_num_w_s <= free_s);
      deq_ack_s = (deq_num_w_s != {PW{1'b0}}) && (deq_num_w_s <= count_r);
      enq_rej_s = (enq_num_w_s != {PW{1'b0}}) && (enq_num_w_s > free_s);
      deq_rej_s = (deq_num_w_s != {PW{1'b0}}) && (deq_num_w_s > count_r);
    end else begin
      enq_ack_s = 1'b0;
      deq_ack_s = 1'b0;
      enq_rej_s = 1'b0;
      deq_rej_s = 1'b0;
    end
  end

  // Per-side pointer/count increments, zero when the side is not accepted
  always_comb begin
    if (enq_ack_s) begin
      enq_add_s = enq_num_w_s;
    end else begin
      enq_add_s = {PW{1'b0}};
    end
    if (deq_ack_s) begin
      deq_sub_s = deq_num_w_s;
    end else begin
      deq_sub_s = {PW{1'b0}};
    end
  end

  // Pointer, occupancy and sticky error state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {PW{1'b0}};
      err_r   <= 1'b0;
    end else if (flush) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {PW{1'b0}};
    end else begin
      tail_r  <= tail_r + enq_add_s;
      head_r  <= head_r + deq_sub_s;
      count_r <= count_r + enq_add_s - deq_sub_s;
      if (enq_rej_s || deq_rej_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Storage write: accepted lanes land at consecutive slots from tail;
  // storage is deliberately not reset, masking hides stale entries
  always_ff @(posedge clk) begin
    for (int i = 0; i < NENQ; i++) begin
      if (enq_ack_s && (i < int'(enq_num))) begin
        mem_r[tail_r[DEPTHEXP-1:0] + DEPTHEXP'(i)] <= enq_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Read lanes from head, zeroing lanes beyond current occupancy
  always_comb begin
    deq_data_s = {(NDEQ*WIDTH){1'b0}};
    for (int i = 0; i < NDEQ; i++) begin
      if (PW'(i) < count_r) begin
        deq_data_s[i*WIDTH +: WIDTH] = mem_r[head_r[DEPTHEXP-1:0] + DEPTHEXP'(i)];
      end else begin
        deq_data_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
      end
    end
  end

  // Number of valid read lanes: min(count, NDEQ)
  always_comb begin
    if (count_r >= PW'(NDEQ)) begin
      deq_avail_s = DW'(NDEQ);
    end else begin
      deq_avail_s = count_r[DW-1:0];
    end
  end

  // Output drive
  always_comb begin
    enq_ack     = enq_ack_s;
    deq_ack     = deq_ack_s;
    deq_data    = deq_data_s;
    deq_avail   = deq_avail_s;
    count       = count_r;
    free_slots  = free_s;
    almost_full = (free_s <= PW'(AF_MARGIN));
    err         = err_r;
  end

endmodule

// File: tb/tb_multi_port_queue.sv
// Directed bench for multi_port_queue with WIDTH=8, DEPTHEXP=2, NENQ=2,
// NDEQ=2, AF_MARGIN=1. Inputs change on the falling edge; acks are checked
// shortly after, registered state shortly after the rising edge.
module tb_multi_port_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  enq_num;
  logic [15:0] enq_data;
  logic        enq_ack;
  logic [1:0]  deq_num;
  logic        deq_ack;
  logic [15:0] deq_data;
  logic [1:0]  deq_avail;
  logic [2:0]  count;
  logic [2:0]  free_slots;
  logic        almost_full;
  logic        err;

  int checks_cnt;
  int errors_cnt;

  multi_port_queue #(
    .WIDTH(8), .DEPTHEXP(2), .NENQ(2), .NDEQ(2), .AF_MARGIN(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_num(enq_num), .enq_data(enq_data), .enq_ack(enq_ack),
    .deq_num(deq_num), .deq_ack(deq_ack), .deq_data(deq_data),
    .deq_avail(deq_avail), .count(count), .free_slots(free_slots),
    .almost_full(almost_full), .err(err)
  );

  // 10 ns clock, first rising edge at 5 ns
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, then let combinational outputs settle
  task automatic drive(input logic [1:0] en, input logic [15:0] ed,
                       input logic [1:0] dn, input logic fl);
    @(negedge clk);
    enq_num  = en;
    enq_data = ed;
    deq_num  = dn;
    flush    = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst      = 1'b0;
    flush    = 1'b0;
    enq_num  = 2'd0;
    enq_data = 16'h0000;
    deq_num  = 2'd0;

    // 1. Reset asserted between edges takes effect without a clock edge
    #7;
    rst     = 1'b1;
    enq_num = 2'd1;
    deq_num = 2'd1;
    #1;
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_free", 32'(free_slots), 32'd4);
    check_val("rst_avail", 32'(deq_avail), 32'd0);
    check_val("rst_data", 32'(deq_data), 32'h0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_af", 32'(almost_full), 32'd0);
    check_val("rst_enq_ack", 32'(enq_ack), 32'd0);
    check_val("rst_deq_ack", 32'(deq_ack), 32'd0);
    tick();
    @(negedge clk);
    rst     = 1'b0;
    enq_num = 2'd0;
    deq_num = 2'd0;

    // 2. Enqueue two entries
    drive(2'd2, 16'hB2A1, 2'd0, 1'b0);
    check_val("t2_enq_ack", 32'(enq_ack), 32'd1);
    check_val("t2_deq_ack", 32'(deq_ack), 32'd0);
    check_val("t2_not_transparent", 32'(deq_data), 32'h0);
    tick();
    check_val("t2_count", 32'(count), 32'd2);
    check_val("t2_avail", 32'(deq_avail), 32'd2);
    check_val("t2_data", 32'(deq_data), 32'hB2A1);
    check_val("t2_free", 32'(free_slots), 32'd2);
    check_val("t2_af", 32'(almost_full), 32'd0);

    // 3. Fill to full, then an overflowing request is rejected
    drive(2'd2, 16'hD4C3, 2'd0, 1'b0);
    check_val("t3_enq_ack", 32'(enq_ack), 32'd1);
    tick();
    check_val("t3_count", 32'(count), 32'd4);
    check_val("t3_af", 32'(almost_full), 32'd1);
    check_val("t3_free", 32'(free_slots), 32'd0);
    check_val("t3_err_clear", 32'(err), 32'd0);
    drive(2'd1, 16'h0077, 2'd0, 1'b0);
    check_val("t3_ovf_ack", 32'(enq_ack), 32'd0);
    tick();
    check_val("t3_err", 32'(err), 32'd1);
    check_val("t3_count_hold", 32'(count), 32'd4);
    check_val("t3_data_hold", 32'(deq_data), 32'hB2A1);

    // 4. Full: dequeue accepted, same-cycle enqueue rejected
    drive(2'd2, 16'h2211, 2'd2, 1'b0);
    check_val("t4_deq_ack", 32'(deq_ack), 32'd1);
    check_val("t4_enq_ack", 32'(enq_ack), 32'd0);
    tick();
    check_val("t4_count", 32'(count), 32'd2);
    check_val("t4_data", 32'(deq_data), 32'hD4C3);
    check_val("t4_err", 32'(err), 32'd1);

    // 5. Wrap-around enqueue into slots 0-1, then drain
    drive(2'd2, 16'hF6E5, 2'd0, 1'b0);
    check_val("t5_enq_ack", 32'(enq_ack), 32'd1);
    tick();
    check_val("t5_count4", 32'(count), 32'd4);
    drive(2'd0, 16'h0000, 2'd2, 1'b0);
    check_val("t5_deq_ack1", 32'(deq_ack), 32'd1);
    check_val("t5_data1", 32'(deq_data), 32'hD4C3);
    tick();
    check_val("t5_data2", 32'(deq_data), 32'hF6E5);
    check_val("t5_count2", 32'(count), 32'd2);
    drive(2'd0, 16'h0000, 2'd2, 1'b0);
    check_val("t5_deq_ack2", 32'(deq_ack), 32'd1);
    tick();
    check_val("t5_count0", 32'(count), 32'd0);
    check_val("t5_data0", 32'(deq_data), 32'h0);
    check_val("t5_avail0", 32'(deq_avail), 32'd0);

    // 6. Build count=3, then flush overrides both sides
    drive(2'd2, 16'h0201, 2'd0, 1'b0);
    tick();
    drive(2'd1, 16'h0003, 2'd0, 1'b0);
    tick();
    check_val("t6_count3", 32'(count), 32'd3);
    check_val("t6_avail2", 32'(deq_avail), 32'd2);
    check_val("t6_data", 32'(deq_data), 32'h0201);
    drive(2'd1, 16'h0044, 2'd1, 1'b1);
    check_val("t6_flush_enq_ack", 32'(enq_ack), 32'd0);
    check_val("t6_flush_deq_ack", 32'(deq_ack), 32'd0);
    tick();
    check_val("t6_count", 32'(count), 32'd0);
    check_val("t6_free", 32'(free_slots), 32'd4);
    check_val("t6_avail", 32'(deq_avail), 32'd0);
    check_val("t6_err_kept", 32'(err), 32'd1);

    // 7. Reset clears err; no-ops and flush-suppressed requests never set it
    @(negedge clk);
    flush   = 1'b0;
    enq_num = 2'd0;
    deq_num = 2'd0;
    rst     = 1'b1;
    #1;
    check_val("t7_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'd0, 16'h0000, 2'd0, 1'b0);
    check_val("t7_noop_enq_ack", 32'(enq_ack), 32'd0);
    check_val("t7_noop_deq_ack", 32'(deq_ack), 32'd0);
    tick();
    check_val("t7_noop_err", 32'(err), 32'd0);
    drive(2'd2, 16'h0000, 2'd1, 1'b1);
    tick();
    check_val("t7_flush_err", 32'(err), 32'd0);
    check_val("t7_flush_count", 32'(count), 32'd0);

    // 8. Enqueue and dequeue together on empty: only enqueue lands, err set
    drive(2'd1, 16'h995A, 2'd1, 1'b0);
    check_val("t8_enq_ack", 32'(enq_ack), 32'd1);
    check_val("t8_deq_ack", 32'(deq_ack), 32'd0);
    tick();
    check_val("t8_err", 32'(err), 32'd1);
    check_val("t8_count", 32'(count), 32'd1);
    check_val("t8_avail", 32'(deq_avail), 32'd1);
    check_val("t8_data_masked", 32'(deq_data), 32'h005A);

    @(negedge clk);
    enq_num = 2'd0;
    deq_num = 2'd0;
    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
